bin_to_bcd_converter: RTL

Sequential binary-to-BCD converter that sits directly upstream of the seven-segment display driver. Converts an unsigned binary value to four packed BCD digits using shift-and-add-3, one bit per clock. Its 16-bit output connects straight to the display driver's num_in, using the same big-endian bit numbering.
- Bits [0:3] = thousands digit (leftmost display digit).
- Bits [12:15] = units digit.

---
 rtl/bin_to_bcd_converter.sv | 109 ++++++++++
 1 files changed

// File: rtl/bin_to_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the seven-segment driver.
// Optional BIN_TO_BCD_HOLD_EN rate-limits num_out/ovf updates to once every HOLD_CYCLES clocks.
module bin_to_bcd_converter #(
    parameter int IN_WIDTH    = 14,
    parameter int HOLD_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [0:IN_WIDTH-1] bin_in,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [0:15]         num_out,
    output logic                ovf
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t              state;
    logic [IN_WIDTH-1:0] bin_sr;
    logic [15:0]         bcd;
    logic [15:0]         bcd_adj;
    logic [15:0]         bcd_next;
    logic [15:0]         result;
    logic [3:0]          bit_cnt;
    logic                ovf_pending;
    logic                in_ovf;
    logic [15:0]         res_num;
    logic                res_ovf;

    assign in_ovf = (32'(bin_in) > 32'd9999);

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[14:0], bin_sr[IN_WIDTH-1]};
        result   = ovf_pending ? 16'hEEEE : bcd_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            bin_sr      <= '0;
            bcd         <= '0;
            bit_cnt     <= '0;
            ovf_pending <= 1'b0;
            res_num     <= '0;
            res_ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr      <= bin_in;
                        bcd         <= '0;
                        ovf_pending <= in_ovf;
                        bit_cnt     <= 4'(IN_WIDTH);
                        busy        <= 1'b1;
                        state       <= CONV;
                    end
                end
                CONV: begin
                    bcd     <= bcd_next;
                    bin_sr  <= {bin_sr[IN_WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt - 4'd1;
                    // Counter at 1 means this edge performs the final shift.
                    if (bit_cnt == 4'd1) begin
                        res_num <= result;
                        res_ovf <= ovf_pending;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BIN_TO_BCD_HOLD_EN
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [HW-1:0] hold_cnt;

    // res_num/res_ovf act as the staging register; outputs copy it only on wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            num_out  <= '0;
            ovf      <= 1'b0;
        end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            hold_cnt <= '0;
            num_out  <= res_num;
            ovf      <= res_ovf;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign num_out = res_num;
    assign ovf     = res_ovf;
`endif

endmodule
